tcam7x64_ctrl: RTL and testbench

Sequencing controller in front of the 7-bit-key, 64-entry SRAM-backed TCAM. The array stores 256 rows of 32 bits: rows 0-127 hold entries 0-31 and rows 128-255 hold entries 32-63, with one row per key value.
- **Searches:** the block issues a one-row read and returns the 64-bit match vector plus a priority-encoded hit index.
- **Updates:** the block converts a ternary entry write (pattern + care mask) into 128 read-modify-write steps, one per key value.
- **Arbitration:** searches and updates share the single array port under a starvation-free scheduler.

---
 rtl/tcam7x64_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_tcam7x64_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam7x64_ctrl.sv
// Sequencing controller for a 7-bit-key, 64-entry SRAM-backed TCAM.
// Converts searches into single-row reads and ternary writes into 128 read-modify-write steps.
module tcam7x64_ctrl #(
    parameter int unsigned KEY_W   = 7,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned ROW_W   = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         sch_valid_i,
    output logic                         sch_ready_o,
    input  logic [KEY_W-1:0]             sch_key_i,
    output logic                         rsp_valid_o,
    output logic [ENTRIES-1:0]           rsp_match_o,
    output logic                         rsp_hit_o,
    output logic [$clog2(ENTRIES)-1:0]   rsp_idx_o,
    input  logic                         upd_valid_i,
    output logic                         upd_ready_o,
    input  logic [$clog2(ENTRIES)-1:0]   upd_idx_i,
    input  logic [KEY_W-1:0]             upd_pat_i,
    input  logic [KEY_W-1:0]             upd_care_i,
    input  logic                         upd_en_i,
    output logic                         upd_done_o,
    output logic                         busy_o,
    output logic                         tcam_csb_o,
    output logic                         tcam_web_o,
    output logic [ROW_W/8-1:0]           tcam_wmask_o,
    output logic [KEY_W:0]               tcam_addr_o,
    output logic [ROW_W-1:0]             tcam_wdata_o,
    input  logic [ENTRIES-1:0]           tcam_rdata_i
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    typedef enum logic [2:0] {IDLE, S_RD, S_RSP, U_RD, U_WR} state_t;

    state_t                 state_q;
    logic [KEY_W-1:0]       key_q;
    logic [IDX_W-1:0]       idx_q;
    logic [KEY_W-1:0]       pat_q;
    logic [KEY_W-1:0]       care_q;
    logic                   en_q;
    logic [KEY_W-1:0]       k_q;
    logic                   sch_last_q;
    logic                   upd_act_q;
    logic                   rsp_valid_q;
    logic [ENTRIES-1:0]     rsp_match_q;
    logic                   rsp_hit_q;
    logic [IDX_W-1:0]       rsp_idx_q;
    logic                   upd_done_q;

    logic                   upd_pending;
    logic                   grant_ok;
    logic                   sch_acc;
    logic                   upd_acc;
    logic                   new_bit;
    logic [ROW_W-1:0]       wr_row;
    logic [IDX_W-1:0]       pe_idx;

    assign upd_pending = ((state_q == IDLE) && upd_valid_i) || upd_act_q;
    assign grant_ok    = !(sch_last_q && upd_pending);
    assign sch_ready_o = rst_ni && grant_ok && ((state_q == IDLE) || (state_q == U_WR));
    assign upd_ready_o = rst_ni && (state_q == IDLE) && !(sch_valid_i && grant_ok);
    assign sch_acc     = sch_valid_i && sch_ready_o;
    assign upd_acc     = upd_valid_i && upd_ready_o;

    assign new_bit = en_q && (((k_q ^ pat_q) & care_q) == '0);

    always_comb begin
        wr_row = idx_q[IDX_W-1] ? tcam_rdata_i[ROW_W +: ROW_W] : tcam_rdata_i[ROW_W-1:0];
        wr_row[idx_q[IDX_W-2:0]] = new_bit;
    end

    // Lowest set bit wins: scan from the top so the last hit assigned is the smallest index.
    always_comb begin
        pe_idx = '0;
        for (int unsigned i = ENTRIES; i > 0; i--) begin
            if (tcam_rdata_i[i-1]) pe_idx = IDX_W'(i - 1);
        end
    end

    always_comb begin
        tcam_csb_o   = 1'b1;
        tcam_web_o   = 1'b1;
        tcam_wmask_o = '0;
        tcam_addr_o  = '0;
        tcam_wdata_o = '0;
        case (state_q)
            S_RD: begin
                tcam_csb_o  = 1'b0;
                tcam_addr_o = {1'b0, key_q};
            end
            U_RD: begin
                tcam_csb_o  = 1'b0;
                tcam_addr_o = {1'b0, k_q};
            end
            U_WR: begin
                tcam_csb_o   = 1'b0;
                tcam_web_o   = 1'b0;
                tcam_addr_o  = {idx_q[IDX_W-1], k_q};
                tcam_wmask_o[idx_q[IDX_W-2:3]] = 1'b1;
                tcam_wdata_o = wr_row;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            key_q       <= '0;
            idx_q       <= '0;
            pat_q       <= '0;
            care_q      <= '0;
            en_q        <= 1'b0;
            k_q         <= '0;
            sch_last_q  <= 1'b0;
            upd_act_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_match_q <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            upd_done_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            upd_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sch_acc) begin
                        key_q      <= sch_key_i;
                        sch_last_q <= 1'b1;
                        state_q    <= S_RD;
                    end else if (upd_acc) begin
                        idx_q      <= upd_idx_i;
                        pat_q      <= upd_pat_i;
                        care_q     <= upd_care_i;
                        en_q       <= upd_en_i;
                        k_q        <= '0;
                        upd_act_q  <= 1'b1;
                        sch_last_q <= 1'b0;
                        state_q    <= U_RD;
                    end
                end
                S_RD: state_q <= S_RSP;
                S_RSP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_match_q <= tcam_rdata_i;
                    rsp_hit_q   <= |tcam_rdata_i;
                    rsp_idx_q   <= pe_idx;
                    state_q     <= upd_act_q ? U_RD : IDLE;
                end
                U_RD: state_q <= U_WR;
                U_WR: begin
                    // The completed key step clears sch_last even when a search is granted here,
                    // so a steadily requesting search gets one slot per key step.
                    sch_last_q <= 1'b0;
                    if (sch_acc) key_q <= sch_key_i;
                    if (k_q == '1) begin
                        upd_done_q <= 1'b1;
                        upd_act_q  <= 1'b0;
                        k_q        <= '0;
                        state_q    <= sch_acc ? S_RD : IDLE;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        state_q <= sch_acc ? S_RD : U_RD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_match_o = rsp_match_q;
    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign upd_done_o  = upd_done_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_tcam7x64_ctrl.sv
// Bench for tcam7x64_ctrl: SRAM array model, logical TCAM model (entry bit per key value),
// per-cycle protocol monitor, directed cases and a randomized phase.
module tb_tcam7x64_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        sch_valid_i = 1'b0;
    logic        sch_ready_o;
    logic [6:0]  sch_key_i = '0;
    logic        rsp_valid_o;
    logic [63:0] rsp_match_o;
    logic        rsp_hit_o;
    logic [5:0]  rsp_idx_o;
    logic        upd_valid_i = 1'b0;
    logic        upd_ready_o;
    logic [5:0]  upd_idx_i = '0;
    logic [6:0]  upd_pat_i = '0;
    logic [6:0]  upd_care_i = '0;
    logic        upd_en_i = 1'b0;
    logic        upd_done_o;
    logic        busy_o;
    logic        tcam_csb_o;
    logic        tcam_web_o;
    logic [3:0]  tcam_wmask_o;
    logic [7:0]  tcam_addr_o;
    logic [31:0] tcam_wdata_o;
    logic [63:0] tcam_rdata_i;

    tcam7x64_ctrl #(.KEY_W(7), .ENTRIES(64), .ROW_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .sch_valid_i(sch_valid_i), .sch_ready_o(sch_ready_o), .sch_key_i(sch_key_i),
        .rsp_valid_o(rsp_valid_o), .rsp_match_o(rsp_match_o), .rsp_hit_o(rsp_hit_o),
        .rsp_idx_o(rsp_idx_o),
        .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .upd_idx_i(upd_idx_i),
        .upd_pat_i(upd_pat_i), .upd_care_i(upd_care_i), .upd_en_i(upd_en_i),
        .upd_done_o(upd_done_o), .busy_o(busy_o),
        .tcam_csb_o(tcam_csb_o), .tcam_web_o(tcam_web_o), .tcam_wmask_o(tcam_wmask_o),
        .tcam_addr_o(tcam_addr_o), .tcam_wdata_o(tcam_wdata_o), .tcam_rdata_i(tcam_rdata_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SRAM array model, driven by port values captured on the falling edge.
    logic [31:0] mem [256];
    logic        mem_init = 1'b0;
    logic        cap_rd = 1'b0, cap_wr = 1'b0;
    logic [7:0]  cap_addr = '0;
    logic [3:0]  cap_mask = '0;
    logic [31:0] cap_wdata = '0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int r = 0; r < 256; r++) mem[r] = '0;
            mem[5] = 32'h0000_0110;
            mem_init = 1'b1;
        end
        if (cap_wr)
            for (int b = 0; b < 4; b++)
                if (cap_mask[b]) mem[cap_addr][b*8 +: 8] = cap_wdata[b*8 +: 8];
        if (cap_rd) tcam_rdata_i <= {mem[{1'b1, cap_addr[6:0]}], mem[{1'b0, cap_addr[6:0]}]};
        else        tcam_rdata_i <= {$urandom, $urandom};
    end

    // Logical model: exp_row[key][entry] = does entry match key.
    typedef struct { int due; logic [6:0] key; } sreq_t;
    typedef struct { int due; logic [63:0] m; } rsp_t;
    sreq_t       sq[$];
    rsp_t        rq[$];
    logic [63:0] exp_row [128];
    logic        model_init = 1'b0;
    logic        sch_last_m = 1'b0;
    logic        upd_active = 1'b0;
    logic        interleaved = 1'b0;
    int          wcnt = 0;
    int          done_due = -1;
    int          s_acc = -100;
    int          upd_acc = 0;
    int          n_upd_srch = 0;
    logic [5:0]  u_idx = '0;
    logic [6:0]  u_pat = '0, u_care = '0;
    logic        u_en = 1'b0;

    always @(negedge clk) begin
        logic        is_wr, is_rd, exp_busy, exp_sr, exp_ur, nb, act0;
        logic [7:0]  a;
        logic [31:0] row;
        logic [5:0]  eidx;
        logic [63:0] m;
        if (!model_init) begin
            for (int r = 0; r < 128; r++) exp_row[r] = '0;
            exp_row[5] = 64'h0000_0000_0000_0110;
            model_init = 1'b1;
        end
        is_wr = !tcam_csb_o && !tcam_web_o;
        is_rd = !tcam_csb_o && tcam_web_o;
        cap_rd = is_rd; cap_wr = is_wr;
        cap_addr = tcam_addr_o; cap_mask = tcam_wmask_o; cap_wdata = tcam_wdata_o;
        if (!rst_ni) begin
            chk("reset_outputs",
                64'({tcam_csb_o, tcam_web_o, sch_ready_o, upd_ready_o, rsp_valid_o, upd_done_o, busy_o}),
                64'(7'b1100000));
            chk("reset_array", 64'({tcam_addr_o, tcam_wmask_o, tcam_wdata_o}), 64'(0));
            sq.delete(); rq.delete();
            upd_active = 1'b0; wcnt = 0; sch_last_m = 1'b0; done_due = -1; s_acc = -100;
        end else begin
            act0 = upd_active;
            exp_busy = upd_active || (cyc - s_acc == 1) || (cyc - s_acc == 2);
            chk("busy", 64'(busy_o), 64'(exp_busy));
            if (!exp_busy) begin
                exp_sr = !(sch_last_m && upd_valid_i);
                exp_ur = !(sch_valid_i && exp_sr);
            end else if (is_wr) begin
                exp_sr = !sch_last_m;
                exp_ur = 1'b0;
            end else begin
                exp_sr = 1'b0;
                exp_ur = 1'b0;
            end
            chk("sch_ready", 64'(sch_ready_o), 64'(exp_sr));
            chk("upd_ready", 64'(upd_ready_o), 64'(exp_ur));
            if (tcam_csb_o)
                chk("array_idle", 64'({tcam_web_o, tcam_addr_o, tcam_wmask_o, tcam_wdata_o}),
                    64'({1'b1, 44'h0}));
            chk("upd_done", 64'(upd_done_o), 64'(cyc == done_due));
            if (cyc == done_due && !interleaved) chk("done_latency", 64'(cyc - upd_acc), 64'(257));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                m = rq[0].m;
                eidx = '0;
                for (int i = 63; i >= 0; i--) if (m[i]) eidx = 6'(i);
                chk("rsp_valid", 64'(rsp_valid_o), 64'(1));
                chk("rsp_match", rsp_match_o, m);
                chk("rsp_hit_idx", 64'({rsp_hit_o, rsp_idx_o}), 64'({m != 0, eidx}));
                void'(rq.pop_front());
            end else begin
                chk("rsp_valid_quiet", 64'(rsp_valid_o), 64'(0));
            end
            if (sq.size() > 0 && sq[0].due == cyc) begin
                chk("srch_rd", 64'({tcam_csb_o, tcam_web_o, tcam_addr_o}), 64'({2'b01, 1'b0, sq[0].key}));
                rq.push_back('{cyc + 2, exp_row[sq[0].key]});
                void'(sq.pop_front());
            end else if (is_rd) begin
                chk("upd_rd", 64'({upd_active, tcam_addr_o, tcam_wmask_o}),
                    64'({1'b1, 1'b0, 7'(wcnt), 4'b0000}));
            end
            if (is_wr) begin
                chk("wr_in_update", 64'(upd_active && wcnt < 128), 64'(1));
                a   = {u_idx[5], 7'(wcnt)};
                nb  = u_en && (((7'(wcnt) ^ u_pat) & u_care) == 7'h00);
                row = mem[a];
                row[u_idx[4:0]] = nb;
                chk("upd_wr", 64'({tcam_addr_o, tcam_wmask_o, tcam_wdata_o}),
                    64'({a, 4'(1 << u_idx[4:3]), row}));
                exp_row[7'(wcnt)][u_idx] = nb;
                wcnt++;
                if (wcnt == 128) begin
                    upd_active = 1'b0;
                    done_due = cyc + 1;
                end
            end
            if (sch_valid_i && sch_ready_o) begin
                sq.push_back('{cyc + 1, sch_key_i});
                s_acc = cyc;
                sch_last_m = 1'b1;
                if (act0) begin
                    interleaved = 1'b1;
                    n_upd_srch++;
                end
            end
            if (upd_valid_i && upd_ready_o) begin
                u_idx = upd_idx_i; u_pat = upd_pat_i; u_care = upd_care_i; u_en = upd_en_i;
                upd_active = 1'b1; wcnt = 0; sch_last_m = 1'b0;
                upd_acc = cyc; interleaved = 1'b0; n_upd_srch = 0;
            end
            if (is_wr) sch_last_m = 1'b0;
        end
    end

    task automatic do_update(input logic [5:0] idx, input logic [6:0] pat, input logic [6:0] care,
                             input logic en, output int acc);
        int t0;
        @(posedge clk); #1;
        upd_valid_i = 1'b1; upd_idx_i = idx; upd_pat_i = pat; upd_care_i = care; upd_en_i = en;
        t0 = cyc;
        do @(negedge clk); while (!upd_ready_o && cyc - t0 < 50);
        chk("upd_accept", 64'(upd_ready_o), 64'(1));
        acc = cyc;
        @(posedge clk); #1;
        upd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int acc, input logic spin, output int dcyc, output int nwr);
        nwr = 0;
        dcyc = -1;
        while (dcyc < 0 && cyc - acc < 2000) begin
            @(posedge clk); #1;
            if (spin) sch_key_i = 7'($urandom);
            @(negedge clk);
            if (!tcam_csb_o && !tcam_web_o && tcam_wmask_o == 4'b0001 && tcam_addr_o[7]) nwr++;
            if (upd_done_o) dcyc = cyc;
        end
        chk("upd_done_seen", 64'(dcyc >= 0), 64'(1));
    endtask

    initial begin
        int acc, d, nwr, bad, t0;

        // Reset with random inputs
        repeat (6) begin
            @(posedge clk); #1;
            sch_valid_i = 1'($urandom); upd_valid_i = 1'($urandom);
            sch_key_i = 7'($urandom); upd_idx_i = 6'($urandom);
        end
        sch_valid_i = 1'b0; upd_valid_i = 1'b0; sch_key_i = '0; upd_idx_i = '0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("idle_readies", 64'({sch_ready_o, upd_ready_o}), 64'(2'b11));

        // Search on preloaded row 5
        @(posedge clk); #1;
        sch_valid_i = 1'b1; sch_key_i = 7'd5;
        @(negedge clk);
        chk("t2_accept", 64'(sch_ready_o), 64'(1));
        acc = cyc;
        @(posedge clk); #1;
        sch_valid_i = 1'b0;
        @(negedge clk);
        chk("t2_addr", 64'({tcam_csb_o, tcam_addr_o}), 64'({1'b0, 8'h05}));
        do @(negedge clk); while (!rsp_valid_o && cyc - acc < 10);
        chk("t2_latency", 64'(cyc - acc), 64'(3));
        chk("t2_match", rsp_match_o, 64'h110);
        chk("t2_hit_idx", 64'({rsp_hit_o, rsp_idx_o}), 64'({1'b1, 6'd4}));

        // Exact-match update of entry 37
        do_update(6'd37, 7'h05, 7'h7F, 1'b1, acc);
        wait_done(acc, 1'b0, d, nwr);
        chk("t3_done_lat", 64'(d - acc), 64'(257));
        chk("t3_writes", 64'(nwr), 64'(128));
        bad = 0;
        for (int r = 128; r < 256; r++) if (mem[r][5] !== (r == 8'h85)) bad++;
        chk("t3_rows", 64'(bad), 64'(0));
        chk("t3_row85", 64'(mem[8'h85]), 64'(32'h20));

        // Don't-care install then invalidate of entry 2
        do_update(6'd2, 7'h00, 7'h00, 1'b1, acc);
        wait_done(acc, 1'b0, d, nwr);
        bad = 0;
        for (int r = 0; r < 128; r++) if (mem[r][2] !== 1'b1) bad++;
        chk("t4_set_rows", 64'(bad), 64'(0));
        do_update(6'd2, 7'h00, 7'h00, 1'b0, acc);
        wait_done(acc, 1'b0, d, nwr);
        bad = 0;
        for (int r = 0; r < 128; r++) if (mem[r][2] !== 1'b0) bad++;
        chk("t4_clr_rows", 64'(bad), 64'(0));

        // Continuous searches interleaved with an update of entry 10
        @(posedge clk); #1;
        sch_valid_i = 1'b1; sch_key_i = 7'($urandom);
        do_update(6'd10, 7'($urandom), 7'($urandom), 1'b1, acc);
        wait_done(acc, 1'b1, d, nwr);
        chk("t5_searches", 64'(n_upd_srch), 64'(128));
        chk("t5_done_lat", 64'(d - acc), 64'(511));
        @(posedge clk); #1;
        sch_valid_i = 1'b0;
        repeat (6) @(posedge clk);

        // Reset in the middle of an update
        do_update(6'd50, 7'($urandom), 7'($urandom), 1'b1, acc);
        while (wcnt < 60 && cyc - acc < 500) @(negedge clk);
        chk("t6_reached_k60", 64'(wcnt), 64'(60));
        @(posedge clk); #1;
        rst_ni = 1'b0;
        #1;
        chk("t6_async_reset",
            64'({tcam_csb_o, tcam_web_o, busy_o, sch_ready_o, upd_ready_o, upd_done_o}),
            64'(6'b110000));
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        do_update(6'd50, 7'h11, 7'h33, 1'b1, acc);
        wait_done(acc, 1'b0, d, nwr);
        chk("t6_fresh_lat", 64'(d - acc), 64'(257));

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            sch_valid_i = ($urandom_range(0, 9) < 4);
            sch_key_i   = 7'($urandom);
            upd_valid_i = ($urandom_range(0, 99) < 4);
            upd_idx_i   = 6'($urandom);
            upd_pat_i   = 7'($urandom);
            upd_care_i  = 7'($urandom);
            upd_en_i    = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        sch_valid_i = 1'b0; upd_valid_i = 1'b0;
        t0 = cyc;
        do @(negedge clk); while ((busy_o || rq.size() > 0) && cyc - t0 < 1000);
        chk("drain_idle", 64'({busy_o, rq.size() > 0}), 64'(0));
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
